// File: rtl/spi_master_ctrl_if.sv
// Signal bundle between the user/test logic and the SPI master controller,
// including the external SPI pins.
interface spi_master_ctrl_if #(
  parameter int LARGO = 8
) ();
  logic             start;
  logic [LARGO-1:0] tx_data;
  logic             miso;
  logic             sclk;
  logic             mosi;
  logic             cs_n;
  logic             busy;
  logic             done;
  logic [LARGO-1:0] rx_data;

  // User/test side: requests transfers, observes the pins and the result.
  modport master (
    output start, tx_data, miso,
    input  sclk, mosi, cs_n, busy, done, rx_data
  );

  // Controller side.
  modport slave (
    input  start, tx_data, miso,
    output sclk, mosi, cs_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one LARGO-bit MSB-first full-duplex transfer per accepted
// start, with SETUP and HOLD guard intervals around the SCLK burst.
module spi_master_ctrl #(
  parameter int LARGO   = 8,
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input logic           clk,
  input logic           rst,
  spi_master_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(LARGO + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LARGO - 1);

  logic [1:0]       state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [LARGO-1:0] tx_q,      tx_d;
  logic [LARGO-1:0] rx_q,      rx_d;
  logic [LARGO-1:0] rx_data_q, rx_data_d;
  logic             sclk_q,    sclk_d;
  logic             mosi_q,    mosi_d;
  logic             cs_n_q,    cs_n_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             div_tc_s;

  assign div_tc_s = (div_q == DIV_LAST);

  // Next-state and datapath decode for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tx_d    = bus.tx_data;
          mosi_d  = bus.tx_data[LARGO-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (div_tc_s) begin
          div_d   = '0;
          state_d = ST_XFER;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_XFER: begin
        if (div_tc_s) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[LARGO-2:0], bus.miso};
          end else begin
            sclk_d = 1'b0;
            cnt_d  = cnt_q + CNT_W'(1);
            // The last falling edge leaves mosi on the final bit through HOLD.
            if (cnt_q == CNT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              tx_d   = {tx_q[LARGO-2:0], 1'b0};
              mosi_d = tx_q[LARGO-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_HOLD: begin
        if (div_tc_s) begin
          div_d     = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          mosi_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a default instance (CLK_DIV=4) and
// a CLK_DIV=1 instance for back-to-back streaming.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.LARGO(8)) bus  ();
  spi_master_ctrl_if #(.LARGO(8)) bus1 ();

  spi_master_ctrl #(.LARGO(8), .CLK_DIV(4), .DIV_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  spi_master_ctrl #(.LARGO(8), .CLK_DIV(1), .DIV_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // 0 = loopback, 1 = miso tied high, 2 = miso tied low
  int miso_mode = 0;
  assign bus.miso  = (miso_mode == 0) ? bus.mosi : ((miso_mode == 1) ? 1'b1 : 1'b0);
  assign bus1.miso = bus1.mosi;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  logic [7:0] sb1[$];

  typedef struct {
    logic [7:0] tx;
    int         mode;
    logic [7:0] exp_rx;
    bit         poke;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] act, input bit which);
    logic [7:0] e;
    if (which ? (sb1.size() == 0) : (sb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s: done with empty scoreboard, got 0x%0h", nm, act);
    end else begin
      e = which ? sb1.pop_front() : sb.pop_front();
      chk(nm, 32'(act), 32'(e));
    end
  endtask

  task automatic run_xfer(input logic [7:0] tx, input int mode, input logic [7:0] exp_rx, input bit poke);
    int n = 0, done_n = -1, rises = 0, run = 0, bad_w = 0, noise = 0;
    logic [7:0] got = 8'h00;
    logic prev;
    @(negedge clk);
    miso_mode    = mode;
    bus.tx_data  = tx;
    bus.start    = 1'b1;
    sb.push_back(exp_rx);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_data = 8'h00;
    chk("busy_rise", 32'(bus.busy), 32'd1);
    prev = bus.sclk;
    while (n < 200 && done_n < 0) begin
      @(negedge clk);
      n++;
      if (poke && n == 19) begin
        bus.start   = 1'b1;
        bus.tx_data = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      if (!prev && bus.sclk) begin
        rises++;
        got = {got[6:0], bus.mosi};
      end
      if (bus.sclk) run++;
      else begin
        if (prev && run != 4) bad_w++;
        run = 0;
      end
      prev = bus.sclk;
      if (bus.done) done_n = n;
    end
    chk("done_latency", 32'(done_n), 32'd72);
    chk("sclk_rises", 32'(rises), 32'd8);
    chk("mosi_pattern", 32'(got), 32'(tx));
    chk("sclk_high_width", 32'(bad_w), 32'd0);
    pop_chk("rx_data", bus.rx_data, 1'b0);
    chk("cs_n_at_done", 32'(bus.cs_n), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.sclk || !bus.cs_n) noise++;
    end
    chk("quiet_after_done", 32'(noise), 32'd0);
  endtask

  initial begin
    int n, rises, seen_done, busy_n, d1, d2, csh;
    logic prev;

    vecs[0] = '{tx: 8'hA5, mode: 0, exp_rx: 8'hA5, poke: 1'b0};
    vecs[1] = '{tx: 8'h3C, mode: 1, exp_rx: 8'hFF, poke: 1'b0};
    vecs[2] = '{tx: 8'h3C, mode: 2, exp_rx: 8'h00, poke: 1'b0};
    vecs[3] = '{tx: 8'hC3, mode: 0, exp_rx: 8'hC3, poke: 1'b1};

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.tx_data  = 8'h00;
    bus1.start   = 1'b0;
    bus1.tx_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start  = ~bus.start;
      bus1.start = ~bus1.start;
    end
    #1;
    chk("reset_pins", 32'({bus.sclk, bus.cs_n, bus.mosi, bus.busy, bus.done}), 32'b01000);
    chk("reset_rx", 32'(bus.rx_data), 32'h0);
    chk("reset_pins_div1", 32'({bus1.sclk, bus1.cs_n, bus1.mosi, bus1.busy, bus1.done}), 32'b01000);
    @(negedge clk);
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_pins", 32'({bus.sclk, bus.cs_n, bus.mosi, bus.busy, bus.done}), 32'b01000);
    chk("post_reset_rx", 32'(bus.rx_data), 32'h0);

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].tx, vecs[i].mode, vecs[i].exp_rx, vecs[i].poke);
    end

    // Abort after the third rising SCLK edge.
    @(negedge clk);
    miso_mode   = 0;
    bus.tx_data = 8'h96;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    rises = 0;
    prev = bus.sclk;
    while (rises < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (!prev && bus.sclk) rises++;
      prev = bus.sclk;
    end
    chk("abort_reached_third_rise", 32'(rises), 32'd3);
    rst = 1'b0;
    #1;
    chk("abort_cs_n", 32'(bus.cs_n), 32'd1);
    chk("abort_sclk", 32'(bus.sclk), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_rx_data", 32'(bus.rx_data), 32'h0);

    run_xfer(8'h5A, 0, 8'h5A, 1'b0);

    // Back-to-back streaming with start held high on the CLK_DIV=1 instance.
    @(negedge clk);
    bus1.tx_data = 8'h81;
    bus1.start   = 1'b1;
    sb1.push_back(8'h81);
    n = 0;
    busy_n = -1;
    d1 = -1;
    d2 = -1;
    csh = 0;
    while (n < 200 && d2 < 0) begin
      @(negedge clk);
      n++;
      if (bus1.busy && busy_n < 0) busy_n = n;
      if (busy_n >= 0 && bus1.cs_n && !(bus1.done && d1 >= 0)) csh++;
      if (bus1.done) begin
        if (d1 < 0) begin
          d1 = n;
          pop_chk("b2b_rx_first", bus1.rx_data, 1'b1);
          bus1.tx_data = 8'h7E;
          sb1.push_back(8'h7E);
        end else begin
          d2 = n;
          pop_chk("b2b_rx_second", bus1.rx_data, 1'b1);
          bus1.start = 1'b0;
        end
      end
    end
    bus1.start = 1'b0;
    chk("b2b_busy_rise", 32'(busy_n), 32'd1);
    chk("b2b_first_len", 32'(d1 - busy_n), 32'd18);
    chk("b2b_done_spacing", 32'(d2 - d1), 32'd19);
    chk("b2b_cs_n_gap", 32'(csh), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
